// File: rtl/l2_arbiter_pkg.sv
// Shared cache package for the L2 arbiter: line geometry constants, the
// arbiter FSM state enum, the grant enum and a line-alignment helper.
package l2_arbiter_pkg;

    localparam int L2_OFFSET = 5;
    localparam int L2_LINE   = 8 * (2 ** L2_OFFSET);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RESP    = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    // Clear the byte-offset bits so the address names a whole line.
    function automatic logic [31:0] line_align(
        input logic [31:0] addr,
        input int          off
    );
        line_align = addr & ~((32'd1 << off) - 32'd1);
    endfunction

endpackage

// File: rtl/l2_arbiter.sv
// Two-into-one L2 line arbiter: instruction and data requesters share one
// L2 port; ties go to the side not served last.
// Ports: clk/rst_n; i_read/i_address -> i_rdata/i_resp (instruction);
//        d_read/d_write/d_address/d_wdata -> d_rdata/d_resp (data);
//        mem_read/mem_write/mem_address/mem_wdata <- mem_rdata/mem_resp (L2).
module l2_arbiter
    import l2_arbiter_pkg::*;
#(
    parameter int s_offset = L2_OFFSET,
    parameter int s_line   = 8 * (2 ** s_offset)
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_read,
    input  logic [31:0]       i_address,
    output logic [s_line-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [31:0]       d_address,
    input  logic [s_line-1:0] d_wdata,
    output logic [s_line-1:0] d_rdata,
    output logic              d_resp,

    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_address,
    output logic [s_line-1:0] mem_wdata,
    input  logic [s_line-1:0] mem_rdata,
    input  logic              mem_resp
);

    arb_state_t        r_state;
    grant_t            r_last_grant;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [31:0]       r_mem_address;
    logic [s_line-1:0] r_mem_wdata;
    logic [s_line-1:0] r_rdata;
    logic              r_i_resp;
    logic              r_d_resp;

    logic              w_i_req;
    logic              w_d_req;
    logic              w_grant_i;
    logic              w_grant_d;

    assign w_i_req   = i_read;
    assign w_d_req   = d_read | d_write;
    // On a tie, D wins only if I was the side served last.
    assign w_grant_d = w_d_req & (~w_i_req | (r_last_grant == GRANT_I));
    assign w_grant_i = w_i_req & ~w_grant_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_last_grant  <= GRANT_I;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
            r_rdata       <= '0;
            r_i_resp      <= 1'b0;
            r_d_resp      <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        r_state       <= SERVE_D;
                        // A read+write collision is served as a write.
                        r_mem_write   <= d_write;
                        r_mem_read    <= ~d_write;
                        r_mem_address <= line_align(d_address, s_offset);
                        r_mem_wdata   <= d_wdata;
                    end else if (w_grant_i) begin
                        r_state       <= SERVE_I;
                        r_mem_write   <= 1'b0;
                        r_mem_read    <= 1'b1;
                        r_mem_address <= line_align(i_address, s_offset);
                        r_mem_wdata   <= d_wdata;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (mem_resp) begin
                        r_state     <= RESP;
                        r_rdata     <= mem_rdata;
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_i_resp    <= (r_state == SERVE_I);
                        r_d_resp    <= (r_state == SERVE_D);
                    end
                end
                RESP: begin
                    r_state      <= IDLE;
                    r_i_resp     <= 1'b0;
                    r_d_resp     <= 1'b0;
                    r_last_grant <= r_d_resp ? GRANT_D : GRANT_I;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Illegal requester behaviour: both data-side strobes at grant time.
    always_ff @(posedge clk) begin
        if (rst_n && r_state == IDLE && w_grant_d) begin
            assert (!(d_read && d_write))
            else $warning("l2_arbiter: d_read and d_write both high at grant");
        end
    end

    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign mem_address = r_mem_address;
    assign mem_wdata   = r_mem_wdata;
    assign i_rdata     = r_rdata;
    assign d_rdata     = r_rdata;
    assign i_resp      = r_i_resp;
    assign d_resp      = r_d_resp;

endmodule

// File: tb/tb_l2_arbiter.sv
// Self-checking bench for l2_arbiter: directed vector table, hand-written
// reset/tie/idle sequences and a randomized transaction-level model.
module tb_l2_arbiter;

    localparam int SO = 5;
    localparam int SL = 8 * (2 ** SO);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_read;
    logic [31:0]   i_address;
    logic [SL-1:0] i_rdata;
    logic          i_resp;
    logic          d_read;
    logic          d_write;
    logic [31:0]   d_address;
    logic [SL-1:0] d_wdata;
    logic [SL-1:0] d_rdata;
    logic          d_resp;
    logic          mem_read;
    logic          mem_write;
    logic [31:0]   mem_address;
    logic [SL-1:0] mem_wdata;
    logic [SL-1:0] mem_rdata;
    logic          mem_resp;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    l2_arbiter #(.s_offset(SO), .s_line(SL)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_read      (i_read),
        .i_address   (i_address),
        .i_rdata     (i_rdata),
        .i_resp      (i_resp),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_address   (d_address),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_resp      (d_resp),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_resp    (mem_resp)
    );

    task automatic chk(input string nm, input logic [SL-1:0] act,
                       input logic [SL-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [SL-1:0] pat(input logic [7:0] b);
        pat = {(SL/8){b}};
    endfunction

    function automatic logic [SL-1:0] rand_line();
        logic [SL-1:0] v;
        for (int k = 0; k < SL/32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Model-level line alignment: round down to a whole line.
    function automatic logic [31:0] line_of(input logic [31:0] a);
        line_of = (a / (2 ** SO)) * (2 ** SO);
    endfunction

    task automatic drop_all();
        i_read    = 1'b0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        i_address = '0;
        d_address = '0;
        d_wdata   = '0;
        mem_resp  = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drop_all();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // One full transaction starting from IDLE. hold = cycles mem op stays up.
    task automatic run_txn(
        input logic          ir, dr, dw,
        input logic [31:0]   ia, da,
        input logic [SL-1:0] wd,
        input int            hold,
        input logic [SL-1:0] rd,
        input logic          exp_d, exp_w,
        input logic [31:0]   exp_a,
        input logic          keep,
        input string         tag
    );
        i_read = ir; d_read = dr; d_write = dw;
        i_address = ia; d_address = da; d_wdata = wd;
        chk({tag, " idle_no_op"}, {mem_read, mem_write}, 0);
        tick();
        chk({tag, " mem_read"}, mem_read, !exp_w);
        chk({tag, " mem_write"}, mem_write, exp_w);
        chk({tag, " mem_address"}, mem_address, exp_a);
        if (exp_w) chk({tag, " mem_wdata"}, mem_wdata, wd);
        chk({tag, " no_early_resp"}, {i_resp, d_resp}, 0);
        for (int c = 1; c < hold; c++) begin
            tick();
            chk({tag, " op_held"}, {mem_read, mem_write, mem_address},
                {!exp_w, exp_w, exp_a});
        end
        mem_resp  = 1'b1;
        mem_rdata = rd;
        tick();
        mem_resp  = 1'b0;
        mem_rdata = ~rd;
        chk({tag, " resp_side"}, {i_resp, d_resp}, {!exp_d, exp_d});
        chk({tag, " rdata"}, exp_d ? d_rdata : i_rdata, rd);
        chk({tag, " op_dropped"}, {mem_read, mem_write}, 0);
        if (!keep) begin
            if (exp_d) begin d_read = 1'b0; d_write = 1'b0; end
            else i_read = 1'b0;
        end
        tick();
        chk({tag, " resp_one_cycle"}, {i_resp, d_resp, mem_read, mem_write}, 0);
    endtask

    typedef struct {
        logic        ir, dr, dw;
        logic [31:0] ia, da;
        logic [7:0]  wb;
        int          hold;
        logic [7:0]  rb;
        logic        exp_d, exp_w;
        logic [31:0] exp_a;
    } vec_t;

    vec_t vecs[7];

    logic          pi, pd, pdw, last_d, win_d;
    logic [31:0]   ai, ad;
    logic [SL-1:0] wdr;

    initial begin
        // ir dr dw  ia  da  wb  hold rb  exp_d exp_w exp_a
        vecs[0] = '{1, 0, 0, 32'h0000_1234, 32'h0, 8'h00, 3, 8'h3C,
                    0, 0, 32'h0000_1220};
        vecs[1] = '{0, 0, 1, 32'h0, 32'h8000_003F, 8'hA5, 2, 8'h5A,
                    1, 1, 32'h8000_0020};
        vecs[2] = '{0, 1, 1, 32'h0, 32'h0000_0047, 8'hC3, 1, 8'h11,
                    1, 1, 32'h0000_0040};
        vecs[3] = '{1, 1, 0, 32'h0000_0100, 32'h0000_02FF, 8'h00, 1, 8'h22,
                    0, 0, 32'h0000_0100};
        vecs[4] = '{1, 1, 0, 32'h0000_011F, 32'h0000_0200, 8'h00, 2, 8'h33,
                    1, 0, 32'h0000_0200};
        vecs[5] = '{0, 1, 0, 32'h0, 32'hFFFF_FFFF, 8'h00, 4, 8'h44,
                    1, 0, 32'hFFFF_FFE0};
        vecs[6] = '{1, 0, 0, 32'h0000_001F, 32'h0, 8'h00, 1, 8'h55,
                    0, 0, 32'h0000_0000};

        // Reset values, sampled while reset is held.
        rst_n = 1'b0;
        drop_all();
        #3;
        chk("rst ctrl", {mem_read, mem_write, i_resp, d_resp}, 0);
        chk("rst mem_address", mem_address, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        chk("rst rdata", i_rdata, 0);
        do_reset();

        // mem_resp in IDLE with no request must do nothing.
        mem_resp  = 1'b1;
        mem_rdata = pat(8'hEE);
        tick();
        tick();
        chk("idle_resp no_resp", {i_resp, d_resp, mem_read, mem_write}, 0);
        chk("idle_resp rdata", d_rdata, 0);
        mem_resp = 1'b0;

        for (int v = 0; v < 7; v++) begin
            run_txn(vecs[v].ir, vecs[v].dr, vecs[v].dw,
                    vecs[v].ia, vecs[v].da, pat(vecs[v].wb),
                    vecs[v].hold, pat(vecs[v].rb),
                    vecs[v].exp_d, vecs[v].exp_w, vecs[v].exp_a,
                    1'b0, $sformatf("vec%0d", v));
        end

        // Both sides held continuously after reset: grants go D, I, D.
        do_reset();
        run_txn(1, 1, 0, 32'h400, 32'h800, '0, 1, pat(8'h01),
                1, 0, 32'h800, 1'b1, "tie1");
        run_txn(1, 1, 0, 32'h400, 32'h800, '0, 2, pat(8'h02),
                0, 0, 32'h400, 1'b1, "tie2");
        run_txn(1, 1, 0, 32'h400, 32'h800, '0, 1, pat(8'h03),
                1, 0, 32'h800, 1'b1, "tie3");
        drop_all();

        // Reset 2 cycles into SERVE_D; the aborted D must not count as served.
        d_read    = 1'b1;
        d_address = 32'h0000_0444;
        tick();
        chk("abort serve_d", {mem_read, mem_address}, {1'b1, 32'h440});
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort ctrl", {mem_read, mem_write, i_resp, d_resp}, 0);
        chk("abort mem_address", mem_address, 0);
        chk("abort mem_wdata", mem_wdata, 0);
        chk("abort rdata", d_rdata, 0);
        drop_all();
        mem_resp  = 1'b1;
        mem_rdata = pat(8'h77);
        tick();
        rst_n = 1'b1;
        tick();
        chk("late_resp ignored", {i_resp, d_resp, mem_read, mem_write}, 0);
        mem_resp = 1'b0;
        run_txn(1, 1, 0, 32'h600, 32'h900, '0, 1, pat(8'h66),
                1, 0, 32'h900, 1'b0, "post_rst_tie");
        drop_all();

        // Random traffic against a pending-set / last-served model.
        do_reset();
        pi = 0; pd = 0; pdw = 0; last_d = 0;
        ai = '0; ad = '0; wdr = '0;
        for (int n = 0; n < 40; n++) begin
            if (!pi && $urandom_range(0, 1) == 1) begin
                pi = 1; ai = $urandom;
            end
            if (!pd && $urandom_range(0, 1) == 1) begin
                pd = 1; ad = $urandom; pdw = 1'($urandom_range(0, 1));
                wdr = rand_line();
            end
            if (!pi && !pd) begin
                pi = 1; ai = $urandom;
            end
            win_d = pd && (!pi || !last_d);
            run_txn(pi, pd && !pdw, pd && pdw, ai, ad, wdr,
                    $urandom_range(1, 5), rand_line(),
                    win_d, win_d && pdw, line_of(win_d ? ad : ai),
                    1'b0, $sformatf("rnd%0d", n));
            if (win_d) pd = 0;
            else pi = 0;
            last_d = win_d;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
